// File: rtl/spawn_collision_checker_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// spawn_collision_checker_if : request/result and board-row-read bundle
// Rev 1.0
// ============================================================================
interface spawn_collision_checker_if #(
  parameter int BOARD_W = 10,
  parameter int X_W     = 4,
  parameter int Y_W     = 5
);
  logic               start;
  logic               mode;
  logic [X_W-1:0]     x;
  logic [Y_W-1:0]     y;
  logic [0:15]        float;
  logic               clr_game_over;
  logic               row_rd_en;
  logic [Y_W-1:0]     row_addr;
  logic [BOARD_W-1:0] row_data;
  logic               busy;
  logic               done;
  logic               collision;
  logic               game_over;

  // master = game controller plus board RAM; slave = checker
  modport master (
    output start, mode, x, y, float, clr_game_over, row_data,
    input  row_rd_en, row_addr, busy, done, collision, game_over
  );

  modport slave (
    input  start, mode, x, y, float, clr_game_over, row_data,
    output row_rd_en, row_addr, busy, done, collision, game_over
  );
endinterface
`default_nettype wire

// File: rtl/spawn_collision_checker.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// spawn_collision_checker : sequential spawn-overlap / lock-height game-over check
// Rev 1.0
// ============================================================================
module spawn_collision_checker #(
  parameter int BOARD_W   = 10,
  parameter int BOARD_H   = 20,
  parameter int X_W       = 4,
  parameter int Y_W       = 5,
  parameter int TOP_GUARD = 2
) (
  input  logic clk,
  input  logic rst_n,
  spawn_collision_checker_if.slave bus
);

  localparam int RW = Y_W + 2;
  localparam int CW = X_W + 2;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SCAN = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]     state_q, state_d;
  logic           mode_q, mode_d;
  logic [X_W-1:0] x_q, x_d;
  logic [Y_W-1:0] y_q, y_d;
  logic [0:15]    float_q, float_d;
  logic [1:0]     r_q, r_d;
  logic           hit_q, hit_d;
  logic           collision_q, collision_d;
  logic           game_over_q, game_over_d;
  logic [Y_W-1:0] row_addr_q, row_addr_d;

  logic [3:0]         nib;
  logic [RW-1:0]      row_idx;
  logic               row_oob;
  logic               col_oob;
  logic [BOARD_W-1:0] piece_row;
  logic               overlap;
  logic               rd_now;

  // Row decode; widened sums make off-board anchors detectable instead of wrapping
  always_comb begin
    nib     = 4'd0;
    col_oob = 1'b0;
    for (int c = 0; c < 4; c++) begin
      nib[c] = float_q[{r_q, 2'(c)}];
      if (float_q[{r_q, 2'(c)}] && ((CW'(x_q) + CW'(c)) >= CW'(BOARD_W)))
        col_oob = 1'b1;
    end
    row_idx   = RW'(y_q) + RW'(r_q);
    row_oob   = (row_idx >= RW'(BOARD_H));
    piece_row = BOARD_W'(nib) << x_q;
    overlap   = |(bus.row_data & piece_row);
    rd_now    = (state_q == S_SCAN) && !mode_q && (nib != 4'd0) && !row_oob && !col_oob;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      mode_q      <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      float_q     <= '0;
      r_q         <= 2'd0;
      hit_q       <= 1'b0;
      collision_q <= 1'b0;
      game_over_q <= 1'b0;
      row_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      x_q         <= x_d;
      y_q         <= y_d;
      float_q     <= float_d;
      r_q         <= r_d;
      hit_q       <= hit_d;
      collision_q <= collision_d;
      game_over_q <= game_over_d;
      row_addr_q  <= row_addr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    x_d         = x_q;
    y_d         = y_q;
    float_d     = float_q;
    r_d         = r_q;
    hit_d       = hit_q;
    collision_d = collision_q;
    game_over_d = game_over_q;
    row_addr_d  = row_addr_q;

    // a hit in DONE below overrides this clear
    if (bus.clr_game_over)
      game_over_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          mode_d  = bus.mode;
          x_d     = bus.x;
          y_d     = bus.y;
          float_d = bus.float;
          hit_d   = 1'b0;
          r_d     = 2'd0;
          state_d = S_SCAN;
        end
      end

      S_SCAN: begin
        if (!mode_q) begin
          if (nib == 4'd0) begin
            if (r_q == 2'd3) state_d = S_DONE;
            else             r_d     = r_q + 2'd1;
          end else if (row_oob || col_oob) begin
            hit_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            row_addr_d = row_idx[Y_W-1:0];
            state_d    = S_WAIT;
          end
        end else begin
          if ((nib != 4'd0) && (row_idx < RW'(TOP_GUARD))) begin
            hit_d   = 1'b1;
            state_d = S_DONE;
          end else if (r_q == 2'd3) begin
            state_d = S_DONE;
          end else begin
            r_d = r_q + 2'd1;
          end
        end
      end

      S_WAIT: begin
        if (overlap) begin
          hit_d   = 1'b1;
          state_d = S_DONE;
        end else if (r_q == 2'd3) begin
          state_d = S_DONE;
        end else begin
          r_d     = r_q + 2'd1;
          state_d = S_SCAN;
        end
      end

      default: begin
        collision_d = hit_q;
        if (hit_q)
          game_over_d = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    bus.row_rd_en = rd_now;
    bus.row_addr  = rd_now ? row_idx[Y_W-1:0] : row_addr_q;
    bus.busy      = (state_q == S_SCAN) || (state_q == S_WAIT);
    bus.done      = (state_q == S_DONE);
    bus.collision = (state_q == S_DONE) ? hit_q : collision_q;
    bus.game_over = game_over_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_spawn_collision_checker.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_spawn_collision_checker : directed self-checking bench for the checker
// Rev 1.0
// ============================================================================
module tb_spawn_collision_checker;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;

  logic [9:0] board [0:31];
  logic [9:0] ram_q = '0;

  always #5 clk = ~clk;

  spawn_collision_checker_if bus ();

  spawn_collision_checker dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // one-cycle-latency board RAM
  always @(posedge clk)
    if (bus.row_rd_en) ram_q <= board[bus.row_addr];
  assign bus.row_data = ram_q;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Cycle 0 = start cycle; reads and done are logged by cycle offset.
  task automatic run_check(input string tag, input logic m, input logic [3:0] xx,
                           input logic [4:0] yy, input logic [15:0] f,
                           input int poke_cyc, input int clr_cyc,
                           input int exp_done, input int exp_col, input int exp_go,
                           input int exp_nrd, input int exp_rd0_cyc, input int exp_rd0_addr,
                           input int exp_rd1_cyc, input int exp_rd1_addr);
    int done_cyc;
    int col;
    int nrd;
    int rd_cyc [2];
    int rd_addr [2];
    done_cyc = -1;
    col      = -1;
    nrd      = 0;
    rd_cyc   = '{-1, -1};
    rd_addr  = '{-1, -1};
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.mode  = m;
    bus.x     = xx;
    bus.y     = yy;
    bus.float = f;
    @(posedge clk); #1;
    for (int k = 1; k <= 20; k++) begin
      if (k == poke_cyc) begin
        bus.start = 1'b1;
        bus.mode  = 1'b1;
        bus.y     = 5'd0;
        bus.float = 16'hFFFF;
      end else begin
        bus.start = 1'b0;
      end
      bus.clr_game_over = (k == clr_cyc);
      @(negedge clk);
      if (k == 1) chk({tag, " busy"}, int'(bus.busy), 1);
      if (bus.row_rd_en) begin
        if (nrd < 2) begin
          rd_cyc[nrd]  = k;
          rd_addr[nrd] = int'(bus.row_addr);
        end
        nrd++;
      end
      if (bus.done) begin
        done_cyc = k;
        col      = int'(bus.collision);
        break;
      end
      @(posedge clk); #1;
    end
    chk({tag, " done_cycle"}, done_cyc, exp_done);
    chk({tag, " collision"}, col, exp_col);
    chk({tag, " reads"}, nrd, exp_nrd);
    if (exp_nrd > 0) begin
      chk({tag, " rd0_cycle"}, rd_cyc[0], exp_rd0_cyc);
      chk({tag, " rd0_addr"}, rd_addr[0], exp_rd0_addr);
    end
    if (exp_nrd > 1) begin
      chk({tag, " rd1_cycle"}, rd_cyc[1], exp_rd1_cyc);
      chk({tag, " rd1_addr"}, rd_addr[1], exp_rd1_addr);
    end
    @(posedge clk); #1;
    bus.start         = 1'b0;
    bus.clr_game_over = 1'b0;
    @(negedge clk);
    chk({tag, " done_single"}, int'(bus.done), 0);
    chk({tag, " col_held"}, int'(bus.collision), exp_col);
    chk({tag, " game_over"}, int'(bus.game_over), exp_go);
  endtask

  task automatic clear_go(input string tag);
    @(posedge clk); #1;
    bus.clr_game_over = 1'b1;
    @(posedge clk); #1;
    bus.clr_game_over = 1'b0;
    @(negedge clk);
    chk({tag, " cleared"}, int'(bus.game_over), 0);
  endtask

  initial begin
    int done_seen;
    rst_n             = 1'b0;
    bus.start         = 1'b0;
    bus.mode          = 1'b0;
    bus.x             = '0;
    bus.y             = '0;
    bus.float         = '0;
    bus.clr_game_over = 1'b0;
    for (int i = 0; i < 32; i++) board[i] = 10'd0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset busy", int'(bus.busy), 0);
    chk("reset done", int'(bus.done), 0);
    chk("reset collision", int'(bus.collision), 0);
    chk("reset game_over", int'(bus.game_over), 0);
    chk("reset row_rd_en", int'(bus.row_rd_en), 0);
    chk("reset row_addr", int'(bus.row_addr), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    run_check("o_empty",  1'b0, 4'd3, 5'd0,  16'h6600, 0, 0, 7, 0, 0, 2, 1, 0, 3, 1);
    board[1] = 10'h010;
    run_check("o_hit",    1'b0, 4'd3, 5'd0,  16'h6600, 0, 0, 5, 1, 1, 2, 1, 0, 3, 1);
    board[1] = 10'h000;
    clear_go("clr1");
    run_check("x_oob",    1'b0, 4'd7, 5'd0,  16'hF000, 0, 0, 2, 1, 1, 0, 0, 0, 0, 0);
    clear_go("clr2");
    run_check("y_oob",    1'b0, 4'd0, 5'd19, 16'h0F00, 0, 0, 3, 1, 1, 0, 0, 0, 0, 0);
    clear_go("clr3");
    run_check("lock_top", 1'b1, 4'd0, 5'd0,  16'h0F00, 0, 0, 3, 1, 1, 0, 0, 0, 0, 0);
    clear_go("clr4");
    run_check("lock_low", 1'b1, 4'd0, 5'd5,  16'h0F00, 0, 0, 5, 0, 0, 0, 0, 0, 0, 0);
    run_check("busy_poke", 1'b0, 4'd3, 5'd0, 16'h6600, 2, 0, 7, 0, 0, 2, 1, 0, 3, 1);
    run_check("clr_vs_set", 1'b1, 4'd0, 5'd0, 16'h0F00, 0, 3, 3, 1, 1, 0, 0, 0, 0, 0);

    // asynchronous reset during the second row read
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.mode  = 1'b0;
    bus.x     = 4'd3;
    bus.y     = 5'd0;
    bus.float = 16'h6600;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    chk("abort pre rd_en", int'(bus.row_rd_en), 1);
    chk("abort pre addr", int'(bus.row_addr), 1);
    rst_n = 1'b0;
    #1;
    chk("abort busy", int'(bus.busy), 0);
    chk("abort row_rd_en", int'(bus.row_rd_en), 0);
    chk("abort row_addr", int'(bus.row_addr), 0);
    chk("abort game_over", int'(bus.game_over), 0);
    chk("abort collision", int'(bus.collision), 0);
    done_seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.done) done_seen++;
    end
    chk("abort no done", done_seen, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_check("post_reset", 1'b0, 4'd3, 5'd0, 16'h6600, 0, 0, 7, 0, 0, 2, 1, 0, 3, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
